// File: rtl/axi_pkg.sv
// Shared AXI constants, the burst master state encoding and a response helper.
package axi_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_DONE
  } state_t;

  // OKAY and EXOKAY both count as success.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/axi_timeout_cnt.sv
// Watchdog down-counter: reloads whenever the channel makes progress and
// flags expiry on the LIMIT-th consecutive stalled cycle.
module axi_timeout_cnt #(
  parameter int LIMIT = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(LIMIT) + 1;
  localparam logic [W-1:0] LOAD_VAL = W'(LIMIT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (load)
      cnt <= LOAD_VAL;
    else if (en && (cnt != '0))
      cnt <= cnt - 1'b1;
  end

  assign expired = en && (cnt == '0);

endmodule

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI INCR burst master: takes one command, runs the
// write or read burst on the AXI channels and reports done/err.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | cmd_ready high, waiting for a command
// ST_WR_ADDR | write address valid, waiting for AWREADY
// ST_WR_DATA | wdata stream passed through, beats 0..len
// ST_WR_RESP | BREADY high, waiting for write response
// ST_RD_ADDR | read address valid, waiting for ARREADY
// ST_RD_DATA | read data passed through to the rdata stream
// ST_DONE    | one-cycle done pulse with sticky err
module axi_burst_master
  import axi_pkg::*;
#(
  parameter int ID_WIDTH = 4,
  parameter int TIMEOUT  = 4096
) (
  input  logic                MASTER_CLK,
  input  logic                MASTER_RSTN,

  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ID_WIDTH-1:0] cmd_id,
  input  logic [31:0]         cmd_addr,
  input  logic [7:0]          cmd_len,

  input  logic [31:0]         wdata,
  input  logic                wdata_valid,
  output logic                wdata_ready,

  output logic [31:0]         rdata,
  output logic                rdata_last,
  output logic                rdata_valid,
  input  logic                rdata_ready,

  output logic                done,
  output logic                err,

  output logic [ID_WIDTH-1:0] MASTER_WR_ADDR_ID,
  output logic [31:0]         MASTER_WR_ADDR_ADDR,
  output logic [7:0]          MASTER_WR_ADDR_LEN,
  output logic [1:0]          MASTER_WR_ADDR_BURST,
  output logic                MASTER_WR_ADDR_VALID,
  input  logic                MASTER_WR_ADDR_READY,

  output logic [31:0]         MASTER_WR_DATA,
  output logic [3:0]          MASTER_WR_DATA_STRB,
  output logic                MASTER_WR_DATA_LAST,
  output logic                MASTER_WR_DATA_VALID,
  input  logic                MASTER_WR_DATA_READY,

  input  logic [ID_WIDTH-1:0] MASTER_WR_BACK_ID,
  input  logic [1:0]          MASTER_WR_BACK_RESP,
  input  logic                MASTER_WR_BACK_VALID,
  output logic                MASTER_WR_BACK_READY,

  output logic [ID_WIDTH-1:0] MASTER_RD_ADDR_ID,
  output logic [31:0]         MASTER_RD_ADDR_ADDR,
  output logic [7:0]          MASTER_RD_ADDR_LEN,
  output logic [1:0]          MASTER_RD_ADDR_BURST,
  output logic                MASTER_RD_ADDR_VALID,
  input  logic                MASTER_RD_ADDR_READY,

  input  logic [ID_WIDTH-1:0] MASTER_RD_BACK_ID,
  input  logic [31:0]         MASTER_RD_BACK_DATA,
  input  logic [1:0]          MASTER_RD_BACK_DATA_RESP,
  input  logic                MASTER_RD_BACK_DATA_LAST,
  input  logic                MASTER_RD_BACK_DATA_VALID,
  output logic                MASTER_RD_DATA_READY
);

  state_t              state, state_nxt;
  logic [ID_WIDTH-1:0] id_q;
  logic [31:0]         addr_q;
  logic [7:0]          len_q;
  logic [7:0]          beat;
  logic                err_q;
  logic                armed;
  logic                accept, w_beat, r_beat, at_last;
  logic                stall, expired;

  assign accept  = cmd_valid && cmd_ready;
  assign at_last = (beat == len_q);
  assign w_beat  = (state == ST_WR_DATA) && wdata_valid && MASTER_WR_DATA_READY;
  assign r_beat  = (state == ST_RD_DATA) && MASTER_RD_BACK_DATA_VALID && rdata_ready;

  always_comb begin
    stall = 1'b0;
    case (state)
      ST_WR_ADDR: stall = !MASTER_WR_ADDR_READY;
      ST_WR_DATA: stall = !w_beat;
      ST_WR_RESP: stall = !MASTER_WR_BACK_VALID;
      ST_RD_ADDR: stall = !MASTER_RD_ADDR_READY;
      ST_RD_DATA: stall = !r_beat;
      default:    stall = 1'b0;
    endcase
  end

  axi_timeout_cnt #(.LIMIT(TIMEOUT)) u_timeout (
    .clk     (MASTER_CLK),
    .rst_n   (MASTER_RSTN),
    .load    (!stall),
    .en      (stall),
    .expired (expired)
  );

  always_ff @(posedge MASTER_CLK or negedge MASTER_RSTN) begin
    if (!MASTER_RSTN)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (accept) state_nxt = cmd_write ? ST_WR_ADDR : ST_RD_ADDR;
      ST_WR_ADDR: if (MASTER_WR_ADDR_READY) state_nxt = ST_WR_DATA;
                  else if (expired) state_nxt = ST_DONE;
      ST_WR_DATA: if (w_beat && at_last) state_nxt = ST_WR_RESP;
                  else if (expired) state_nxt = ST_DONE;
      ST_WR_RESP: if (MASTER_WR_BACK_VALID || expired) state_nxt = ST_DONE;
      ST_RD_ADDR: if (MASTER_RD_ADDR_READY) state_nxt = ST_RD_DATA;
                  else if (expired) state_nxt = ST_DONE;
      ST_RD_DATA: if ((r_beat && (MASTER_RD_BACK_DATA_LAST || at_last)) || expired)
                    state_nxt = ST_DONE;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // armed keeps cmd_ready low until the first edge after reset release.
  always_ff @(posedge MASTER_CLK or negedge MASTER_RSTN) begin
    if (!MASTER_RSTN) begin
      id_q   <= '0;
      addr_q <= '0;
      len_q  <= '0;
      beat   <= '0;
      err_q  <= 1'b0;
      armed  <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (accept) begin
        id_q   <= cmd_id;
        addr_q <= cmd_addr;
        len_q  <= cmd_len;
        beat   <= '0;
        err_q  <= 1'b0;
      end
      if (w_beat || r_beat)
        beat <= beat + 1'b1;
      if ((state == ST_WR_RESP) && MASTER_WR_BACK_VALID &&
          (resp_is_err(MASTER_WR_BACK_RESP) || (MASTER_WR_BACK_ID != id_q)))
        err_q <= 1'b1;
      // Both an early LAST and a missing LAST on the final beat are errors.
      if (r_beat && (resp_is_err(MASTER_RD_BACK_DATA_RESP) ||
                     (MASTER_RD_BACK_ID != id_q) ||
                     (MASTER_RD_BACK_DATA_LAST != at_last)))
        err_q <= 1'b1;
      if (expired)
        err_q <= 1'b1;
      if (state == ST_DONE)
        err_q <= 1'b0;
    end
  end

  assign MASTER_WR_ADDR_ID   = id_q;
  assign MASTER_WR_ADDR_ADDR = addr_q;
  assign MASTER_WR_ADDR_LEN  = len_q;
  assign MASTER_RD_ADDR_ID   = id_q;
  assign MASTER_RD_ADDR_ADDR = addr_q;
  assign MASTER_RD_ADDR_LEN  = len_q;

  always_comb begin
    cmd_ready            = 1'b0;
    wdata_ready          = 1'b0;
    rdata                = '0;
    rdata_last           = 1'b0;
    rdata_valid          = 1'b0;
    done                 = 1'b0;
    err                  = 1'b0;
    MASTER_WR_ADDR_BURST = 2'b00;
    MASTER_WR_ADDR_VALID = 1'b0;
    MASTER_WR_DATA       = '0;
    MASTER_WR_DATA_STRB  = 4'h0;
    MASTER_WR_DATA_LAST  = 1'b0;
    MASTER_WR_DATA_VALID = 1'b0;
    MASTER_WR_BACK_READY = 1'b0;
    MASTER_RD_ADDR_BURST = 2'b00;
    MASTER_RD_ADDR_VALID = 1'b0;
    MASTER_RD_DATA_READY = 1'b0;
    case (state)
      ST_IDLE:    cmd_ready = armed;
      ST_WR_ADDR: begin
        MASTER_WR_ADDR_BURST = BURST_INCR;
        MASTER_WR_ADDR_VALID = 1'b1;
      end
      ST_WR_DATA: begin
        MASTER_WR_DATA       = wdata;
        MASTER_WR_DATA_STRB  = 4'hF;
        MASTER_WR_DATA_LAST  = at_last;
        MASTER_WR_DATA_VALID = wdata_valid;
        wdata_ready          = MASTER_WR_DATA_READY;
      end
      ST_WR_RESP: MASTER_WR_BACK_READY = 1'b1;
      ST_RD_ADDR: begin
        MASTER_RD_ADDR_BURST = BURST_INCR;
        MASTER_RD_ADDR_VALID = 1'b1;
      end
      ST_RD_DATA: begin
        rdata                = MASTER_RD_BACK_DATA;
        rdata_last           = MASTER_RD_BACK_DATA_LAST;
        rdata_valid          = MASTER_RD_BACK_DATA_VALID;
        MASTER_RD_DATA_READY = rdata_ready;
      end
      ST_DONE: begin
        done = 1'b1;
        err  = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master with a small AXI slave model in tasks.
module tb_axi_burst_master;
  localparam int IDW = 4;
  localparam int TMO = 64;

  logic            clk = 1'b0, rst_n = 1'b0;
  logic            cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [IDW-1:0]  cmd_id = '0;
  logic [31:0]     cmd_addr = '0;
  logic [7:0]      cmd_len = '0;
  logic [31:0]     wdata = '0;
  logic            wdata_valid = 0, wdata_ready;
  logic [31:0]     rdata;
  logic            rdata_last, rdata_valid, rdata_ready = 0;
  logic            done, err;
  logic [IDW-1:0]  aw_id_o, ar_id_o;
  logic [31:0]     aw_addr_o, ar_addr_o;
  logic [7:0]      aw_len_o, ar_len_o;
  logic [1:0]      aw_burst_o, ar_burst_o;
  logic            aw_valid, aw_ready = 0, ar_valid, ar_ready = 0;
  logic [31:0]     w_data;
  logic [3:0]      w_strb;
  logic            w_last, w_valid, w_ready = 0;
  logic [IDW-1:0]  b_id_i = '0;
  logic [1:0]      b_resp_i = '0;
  logic            b_valid = 0, b_ready;
  logic [IDW-1:0]  r_id_i = '0;
  logic [31:0]     r_data_i = '0;
  logic [1:0]      r_resp_i = '0;
  logic            r_last_i = 0, r_valid = 0, r_ready;

  always #5 clk = ~clk;

  axi_burst_master #(.ID_WIDTH(IDW), .TIMEOUT(TMO)) dut (
    .MASTER_CLK(clk), .MASTER_RSTN(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_id(cmd_id), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .rdata(rdata), .rdata_last(rdata_last), .rdata_valid(rdata_valid), .rdata_ready(rdata_ready),
    .done(done), .err(err),
    .MASTER_WR_ADDR_ID(aw_id_o), .MASTER_WR_ADDR_ADDR(aw_addr_o), .MASTER_WR_ADDR_LEN(aw_len_o),
    .MASTER_WR_ADDR_BURST(aw_burst_o), .MASTER_WR_ADDR_VALID(aw_valid), .MASTER_WR_ADDR_READY(aw_ready),
    .MASTER_WR_DATA(w_data), .MASTER_WR_DATA_STRB(w_strb), .MASTER_WR_DATA_LAST(w_last),
    .MASTER_WR_DATA_VALID(w_valid), .MASTER_WR_DATA_READY(w_ready),
    .MASTER_WR_BACK_ID(b_id_i), .MASTER_WR_BACK_RESP(b_resp_i), .MASTER_WR_BACK_VALID(b_valid),
    .MASTER_WR_BACK_READY(b_ready),
    .MASTER_RD_ADDR_ID(ar_id_o), .MASTER_RD_ADDR_ADDR(ar_addr_o), .MASTER_RD_ADDR_LEN(ar_len_o),
    .MASTER_RD_ADDR_BURST(ar_burst_o), .MASTER_RD_ADDR_VALID(ar_valid), .MASTER_RD_ADDR_READY(ar_ready),
    .MASTER_RD_BACK_ID(r_id_i), .MASTER_RD_BACK_DATA(r_data_i), .MASTER_RD_BACK_DATA_RESP(r_resp_i),
    .MASTER_RD_BACK_DATA_LAST(r_last_i), .MASTER_RD_BACK_DATA_VALID(r_valid),
    .MASTER_RD_DATA_READY(r_ready)
  );

  int vectors = 0, miscompares = 0;
  logic [31:0] mem [0:511];

  // Results recorded by the slave-model drivers, judged by the test tasks.
  int beats, last_cnt, last_idx, accepts, a_hs, avalid_cycles, strb_bad, pass_bad;
  logic done_seen, err_seen, avalid_at_done;
  logic [31:0] a_addr;
  logic [7:0] a_len;
  logic [1:0] a_burst;
  logic [IDW-1:0] a_id;
  logic [31:0] rd_cap [0:255];
  logic rl_cap [0:255];

  logic aw_ready_en = 1, stall_pattern = 0, hold_cmd = 0;
  logic [IDW-1:0] b_id_cfg = '0, r_id_cfg = '0;
  logic [1:0] b_resp_cfg = '0;
  logic [1:0] r_resp_cfg [0:255];
  int r_last_at = 0;

  task automatic clear_results();
    beats = 0; last_cnt = 0; last_idx = -1; accepts = 0; a_hs = 0; avalid_cycles = 0;
    strb_bad = 0; pass_bad = 0; done_seen = 0; err_seen = 0; avalid_at_done = 1'b1;
    a_addr = '0; a_len = '0; a_burst = '0; a_id = '0;
  endtask

  task automatic run_write(input logic [IDW-1:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [31:0] base);
    int cyc;
    logic accepted, b_done;
    clear_results();
    accepted = 0; b_done = 0; cyc = 0;
    cmd_valid = 1; cmd_write = 1; cmd_id = id; cmd_addr = addr; cmd_len = len;
    wdata_valid = 1; wdata = base; aw_ready = aw_ready_en; w_ready = 1;
    b_id_i = b_id_cfg; b_resp_i = b_resp_cfg;
    while (!done_seen && cyc < 3000) begin
      @(negedge clk);
      if (cmd_valid && cmd_ready) begin accepts++; accepted = 1; end
      if (aw_valid) avalid_cycles++;
      if (aw_valid && aw_ready) begin
        a_hs++; a_addr = aw_addr_o; a_len = aw_len_o; a_burst = aw_burst_o; a_id = aw_id_o;
      end
      if (w_valid && w_ready) begin
        mem[(int'(a_addr) + beats) % 512] = w_data;
        if (w_strb !== 4'hF) strb_bad++;
        if (w_last) begin last_cnt++; last_idx = beats; end
        beats++;
      end
      if (b_valid && b_ready) b_done = 1;
      if (done) begin done_seen = 1; err_seen = err; avalid_at_done = aw_valid; end
      @(posedge clk); #1;
      cyc++;
      if (accepted && !hold_cmd) cmd_valid = 0;
      if (accepted && hold_cmd) begin cmd_write = 0; cmd_addr = 32'h1F0; end
      wdata = base + beats;
      w_ready = stall_pattern ? (cyc % 3 != 0) : 1'b1;
      b_valid = (beats == int'(len) + 1) && !b_done;
    end
    cmd_valid = 0; wdata_valid = 0; b_valid = 0; aw_ready = 0; w_ready = 0;
  endtask

  task automatic run_read(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [7:0] len);
    int cyc;
    logic accepted;
    clear_results();
    accepted = 0; cyc = 0;
    cmd_valid = 1; cmd_write = 0; cmd_id = id; cmd_addr = addr; cmd_len = len;
    ar_ready = 1; rdata_ready = 1; r_id_i = r_id_cfg;
    while (!done_seen && cyc < 3000) begin
      @(negedge clk);
      if (cmd_valid && cmd_ready) begin accepts++; accepted = 1; end
      if (ar_valid && ar_ready) begin
        a_hs++; a_addr = ar_addr_o; a_len = ar_len_o; a_burst = ar_burst_o; a_id = ar_id_o;
      end
      if (rdata_valid && rdata_ready) begin
        if (rdata !== r_data_i || rdata_last !== r_last_i) pass_bad++;
        rd_cap[beats] = rdata; rl_cap[beats] = rdata_last;
        if (rdata_last) begin last_cnt++; last_idx = beats; end
        beats++;
      end
      if (done) begin done_seen = 1; err_seen = err; avalid_at_done = ar_valid; end
      @(posedge clk); #1;
      cyc++;
      if (accepted && !hold_cmd) cmd_valid = 0;
      rdata_ready = stall_pattern ? (cyc % 3 != 0) : 1'b1;
      r_valid  = (a_hs > 0) && (beats <= r_last_at) && !done_seen;
      r_data_i = mem[(int'(a_addr) + beats) % 512];
      r_resp_i = (beats <= 255) ? r_resp_cfg[beats] : 2'b00;
      r_last_i = (beats == r_last_at);
    end
    cmd_valid = 0; r_valid = 0; r_last_i = 0; ar_ready = 0; rdata_ready = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL rst_cmd_ready: got %0b want 0", cmd_ready); end
    vectors++; if ({done, err} !== 2'b00) begin miscompares++; $display("FAIL rst_done_err: got %b want 00", {done, err}); end
    vectors++; if ({aw_valid, w_valid, w_last, b_ready, ar_valid, r_ready, rdata_valid, wdata_ready} !== 8'h00) begin
      miscompares++; $display("FAIL rst_handshakes: got %b want 00000000",
        {aw_valid, w_valid, w_last, b_ready, ar_valid, r_ready, rdata_valid, wdata_ready}); end
    @(negedge clk); rst_n = 1; #1;
    vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL rst_release_ready: got %0b want 0", cmd_ready); end
    @(posedge clk); #1;
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rst_first_edge_ready: got %0b want 1", cmd_ready); end
  endtask

  task automatic test_write_burst();
    b_id_cfg = 4'd2; b_resp_cfg = 2'b00;
    run_write(4'd2, 32'h10, 8'd3, 32'hA0);
    vectors++; if (done_seen !== 1'b1) begin miscompares++; $display("FAIL wr_done: got %0b want 1", done_seen); end
    vectors++; if (err_seen !== 1'b0) begin miscompares++; $display("FAIL wr_err: got %0b want 0", err_seen); end
    vectors++; if ({a_addr, a_len, a_burst, a_id} !== {32'h10, 8'd3, 2'b01, 4'd2}) begin miscompares++;
      $display("FAIL wr_aw_fields: got addr=%0h len=%0d burst=%0b id=%0d want 10/3/01/2", a_addr, a_len, a_burst, a_id); end
    vectors++; if (beats !== 4) begin miscompares++; $display("FAIL wr_beats: got %0d want 4", beats); end
    vectors++; if (last_cnt !== 1 || last_idx !== 3) begin miscompares++;
      $display("FAIL wr_last: got cnt=%0d idx=%0d want 1/3", last_cnt, last_idx); end
    vectors++; if (strb_bad !== 0) begin miscompares++; $display("FAIL wr_strb: got %0d bad beats want 0", strb_bad); end
    for (int i = 0; i < 4; i++) begin
      vectors++; if (mem[16 + i] !== 32'hA0 + i) begin miscompares++;
        $display("FAIL wr_mem[%0d]: got %0h want %0h", 16 + i, mem[16 + i], 32'hA0 + i); end
    end
  endtask

  task automatic test_read_burst();
    r_id_cfg = 4'd2; r_last_at = 3;
    r_resp_cfg[0] = 2'b01; r_resp_cfg[1] = 2'b01; r_resp_cfg[2] = 2'b01; r_resp_cfg[3] = 2'b00;
    run_read(4'd2, 32'h10, 8'd3);
    vectors++; if (done_seen !== 1'b1 || err_seen !== 1'b0) begin miscompares++;
      $display("FAIL rd_done_err: got done=%0b err=%0b want 1/0", done_seen, err_seen); end
    vectors++; if ({a_addr, a_len, a_burst} !== {32'h10, 8'd3, 2'b01}) begin miscompares++;
      $display("FAIL rd_ar_fields: got addr=%0h len=%0d burst=%0b want 10/3/01", a_addr, a_len, a_burst); end
    vectors++; if (beats !== 4) begin miscompares++; $display("FAIL rd_beats: got %0d want 4", beats); end
    for (int i = 0; i < 4; i++) begin
      vectors++; if (rd_cap[i] !== 32'hA0 + i || rl_cap[i] !== (i == 3)) begin miscompares++;
        $display("FAIL rd_beat[%0d]: got %0h last=%0b want %0h last=%0b", i, rd_cap[i], rl_cap[i], 32'hA0 + i, (i == 3)); end
    end
    vectors++; if (pass_bad !== 0) begin miscompares++; $display("FAIL rd_passthru: got %0d bad want 0", pass_bad); end
    r_resp_cfg[0] = 2'b00; r_resp_cfg[1] = 2'b00; r_resp_cfg[2] = 2'b00;
  endtask

  task automatic test_len_bounds();
    r_id_cfg = 4'd1; r_last_at = 0;
    run_read(4'd1, 32'h12, 8'd0);
    vectors++; if (beats !== 1 || rl_cap[0] !== 1'b1 || rd_cap[0] !== 32'hA2) begin miscompares++;
      $display("FAIL rd_len0: got beats=%0d last=%0b data=%0h want 1/1/a2", beats, rl_cap[0], rd_cap[0]); end
    vectors++; if (done_seen !== 1'b1 || err_seen !== 1'b0) begin miscompares++;
      $display("FAIL rd_len0_done: got done=%0b err=%0b want 1/0", done_seen, err_seen); end
    b_id_cfg = 4'd3;
    run_write(4'd3, 32'h100, 8'd255, 32'h1000);
    vectors++; if (beats !== 256) begin miscompares++; $display("FAIL wr_len255_beats: got %0d want 256", beats); end
    vectors++; if (last_cnt !== 1 || last_idx !== 255) begin miscompares++;
      $display("FAIL wr_len255_last: got cnt=%0d idx=%0d want 1/255", last_cnt, last_idx); end
    vectors++; if (mem[256] !== 32'h1000 || mem[511] !== 32'h10FF || err_seen !== 1'b0) begin miscompares++;
      $display("FAIL wr_len255_mem: got %0h %0h err=%0b want 1000 10ff 0", mem[256], mem[511], err_seen); end
  endtask

  task automatic test_errors();
    r_id_cfg = 4'd5; r_last_at = 1;
    run_read(4'd2, 32'h10, 8'd1);
    vectors++; if (done_seen !== 1'b1 || err_seen !== 1'b1) begin miscompares++;
      $display("FAIL err_rid: got done=%0b err=%0b want 1/1", done_seen, err_seen); end
    b_id_cfg = 4'd4;
    run_write(4'd6, 32'h40, 8'd0, 32'h77);
    vectors++; if (done_seen !== 1'b1 || err_seen !== 1'b1) begin miscompares++;
      $display("FAIL err_bid: got done=%0b err=%0b want 1/1", done_seen, err_seen); end
    r_id_cfg = 4'd2; r_last_at = 1; r_resp_cfg[1] = 2'b10;
    run_read(4'd2, 32'h10, 8'd1);
    vectors++; if (err_seen !== 1'b1) begin miscompares++; $display("FAIL err_slverr: got %0b want 1", err_seen); end
    r_resp_cfg[1] = 2'b00;
    r_last_at = 1;
    run_read(4'd2, 32'h10, 8'd3);
    vectors++; if (beats !== 2 || done_seen !== 1'b1 || err_seen !== 1'b1) begin miscompares++;
      $display("FAIL err_early_last: got beats=%0d done=%0b err=%0b want 2/1/1", beats, done_seen, err_seen); end
    r_last_at = 3;
    run_read(4'd2, 32'h10, 8'd1);
    vectors++; if (beats !== 2 || done_seen !== 1'b1 || err_seen !== 1'b1) begin miscompares++;
      $display("FAIL err_missing_last: got beats=%0d done=%0b err=%0b want 2/1/1", beats, done_seen, err_seen); end
  endtask

  task automatic test_timeout();
    aw_ready_en = 0;
    run_write(4'd1, 32'h20, 8'd0, 32'h5);
    aw_ready_en = 1;
    vectors++; if (done_seen !== 1'b1 || err_seen !== 1'b1) begin miscompares++;
      $display("FAIL tmo_done_err: got done=%0b err=%0b want 1/1", done_seen, err_seen); end
    vectors++; if (avalid_cycles !== TMO) begin miscompares++;
      $display("FAIL tmo_cycles: got %0d want %0d", avalid_cycles, TMO); end
    vectors++; if (avalid_at_done !== 1'b0 || a_hs !== 0) begin miscompares++;
      $display("FAIL tmo_awvalid: got valid_at_done=%0b hs=%0d want 0/0", avalid_at_done, a_hs); end
  endtask

  task automatic test_back_to_back();
    hold_cmd = 1; stall_pattern = 1; b_id_cfg = 4'd7; b_resp_cfg = 2'b01;
    run_write(4'd7, 32'h80, 8'd2, 32'hC0);
    vectors++; if (accepts !== 1 || a_hs !== 1) begin miscompares++;
      $display("FAIL b2b_single_accept: got accepts=%0d aw=%0d want 1/1", accepts, a_hs); end
    vectors++; if (beats !== 3 || err_seen !== 1'b0 || mem[130] !== 32'hC2) begin miscompares++;
      $display("FAIL b2b_write: got beats=%0d err=%0b mem=%0h want 3/0/c2", beats, err_seen, mem[130]); end
    hold_cmd = 0; r_id_cfg = 4'd7; r_last_at = 2;
    run_read(4'd7, 32'h80, 8'd2);
    vectors++; if (beats !== 3 || rd_cap[1] !== 32'hC1 || rl_cap[2] !== 1'b1 || err_seen !== 1'b0) begin miscompares++;
      $display("FAIL b2b_read: got beats=%0d d1=%0h last2=%0b err=%0b want 3/c1/1/0", beats, rd_cap[1], rl_cap[2], err_seen); end
    stall_pattern = 0;
  endtask

  task automatic test_reset_mid_read();
    int rb, cyc;
    logic accepted, done_after;
    rb = 0; cyc = 0; accepted = 0; done_after = 0;
    cmd_valid = 1; cmd_write = 0; cmd_id = 4'd1; cmd_addr = 32'h10; cmd_len = 8'd7;
    ar_ready = 1; rdata_ready = 1; r_id_i = 4'd1; r_data_i = 32'h55; r_resp_i = 2'b00;
    r_last_i = 0; r_valid = 1;
    while (rb < 2 && cyc < 100) begin
      @(negedge clk);
      if (cmd_valid && cmd_ready) accepted = 1;
      if (rdata_valid && rdata_ready) rb++;
      @(posedge clk); #1;
      cyc++;
      if (accepted) cmd_valid = 0;
    end
    vectors++; if (rb !== 2) begin miscompares++; $display("FAIL mid_rst_reach_beat2: got %0d beats want 2", rb); end
    #1 rst_n = 0; #1;
    vectors++; if ({rdata_valid, r_ready, rdata_last, done, err, cmd_ready, ar_valid} !== 7'b0 || rdata !== 32'h0) begin
      miscompares++; $display("FAIL mid_rst_outputs: got %b rdata=%0h want 0000000 0",
        {rdata_valid, r_ready, rdata_last, done, err, cmd_ready, ar_valid}, rdata); end
    r_valid = 0; ar_ready = 0; rdata_ready = 0;
    @(negedge clk); rst_n = 1; #1;
    vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL mid_rst_release: got %0b want 0", cmd_ready); end
    @(posedge clk); #1;
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL mid_rst_ready: got %0b want 1", cmd_ready); end
    repeat (4) begin @(negedge clk); if (done) done_after = 1; end
    vectors++; if (done_after !== 1'b0) begin miscompares++; $display("FAIL mid_rst_no_done: got %0b want 0", done_after); end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = '0;
    for (int i = 0; i < 256; i++) r_resp_cfg[i] = 2'b00;
    test_reset();
    test_write_burst();
    test_read_burst();
    test_len_bounds();
    test_errors();
    test_timeout();
    test_back_to_back();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_watchdog: got no completion want finish before 2ms");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axi_burst_master.md
AXI_BURST_MASTER -- requirements
Module: axi_burst_master

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 4, AXI ID width.
REQ-002 SHALL have parameter TIMEOUT, default 4096, watchdog limit in cycles per channel wait.
REQ-003 SHALL have port MASTER_CLK  in  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port MASTER_RSTN  in  1  asynchronous, active-low reset.
REQ-005 SHALL have cmd_valid/cmd_ready  in/out  1/1  command handshake.
REQ-006 SHALL have cmd_write, cmd_id, cmd_addr, cmd_len  in  1/ID_WIDTH/32/8  direction (1=write), ID, word address, beats-1.
REQ-007 SHALL have wdata, wdata_valid/wdata_ready  in/in/out  32/1/1  write-data stream.
REQ-008 SHALL have rdata, rdata_last, rdata_valid/rdata_ready  out/out/out/in  32/1/1/1  read-data stream.
REQ-009 SHALL have done, err  out  1/1  one-cycle completion pulse; error qualifier valid with done.
REQ-010 SHALL have MASTER_WR_ADDR_ID/ADDR/LEN/BURST/VALID out, MASTER_WR_ADDR_READY in; widths ID_WIDTH/32/8/2/1/1.
REQ-011 SHALL have MASTER_WR_DATA/STRB/LAST/VALID out, MASTER_WR_DATA_READY in; widths 32/4/1/1/1.
REQ-012 SHALL have MASTER_WR_BACK_ID/RESP/VALID in, MASTER_WR_BACK_READY out; widths ID_WIDTH/2/1/1.
REQ-013 SHALL have MASTER_RD_ADDR_ID/ADDR/LEN/BURST/VALID out, MASTER_RD_ADDR_READY in; same widths as write address.
REQ-014 SHALL have MASTER_RD_BACK_ID/DATA/DATA_RESP/DATA_LAST/DATA_VALID in, MASTER_RD_DATA_READY out; widths ID_WIDTH/32/2/1/1/1.

Function
REQ-015 SHALL run FSM IDLE -> {WR_ADDR -> WR_DATA -> WR_RESP | RD_ADDR -> RD_DATA} -> DONE -> IDLE; one transaction outstanding.
REQ-016 SHALL assert cmd_ready only in IDLE; command fields registered on cmd_valid&&cmd_ready; next state chosen by cmd_write.
REQ-017 SHALL drive BURST=2'b01 (INCR), ADDR/LEN/ID from registered command; VALID held until READY; no combinational READY->VALID path.
REQ-018 WR_DATA: MASTER_WR_DATA_VALID = wdata_valid; wdata_ready = MASTER_WR_DATA_READY (combinational pass-through); STRB=4'hF; beat counter 0..cmd_len.
REQ-019 SHALL assert MASTER_WR_DATA_LAST exactly on beat cmd_len; after that handshake go WR_RESP.
REQ-020 WR_RESP: MASTER_WR_BACK_READY=1; accept BVALID; err if RESP[1]=1 or BID != cmd_id.
REQ-021 RD_DATA: rdata* = MASTER_RD_BACK_*; MASTER_RD_DATA_READY = rdata_ready; RESP 2'b00 and 2'b01 both OK, RESP[1]=1 sets sticky err.
REQ-022 SHALL set err if RID != cmd_id, if DATA_LAST arrives before beat cmd_len (then exit), or if beat cmd_len lacks DATA_LAST (exit regardless).
REQ-023 SHALL count idle wait cycles in WR_ADDR, WR_RESP, RD_ADDR and stalled data phases; reaching TIMEOUT -> err, drop all VALID/READY, go DONE.
REQ-024 DONE lasts one cycle: done=1, err=sticky error; err cleared on IDLE entry.
REQ-025 cmd_len=0 SHALL yield single beat with LAST=1; cmd_len=255 SHALL yield 256 beats, 8-bit counter not wrapping early.
REQ-026 cmd_valid outside IDLE SHALL be ignored (held by upstream).

Reset
REQ-027 On MASTER_RSTN low, asynchronously: state=IDLE, all VALID/READY, done, err, LAST, counters = 0; cmd_ready=0 until first edge after release.
REQ-028 Reset mid-burst SHALL abort immediately with no further beats; no done pulse.

Structure
REQ-029 Shared package axi_pkg SHALL hold BURST_INCR, RESP_OKAY/EXOKAY/SLVERR/DECERR, state enum.
REQ-030 One sub-module axi_timeout_cnt (load/clear, expire flag) SHALL implement the watchdog.

Verification
REQ-031 Write addr=0x10,len=3, data 0xA0..0xA3, slave OKAY -> 4 beats, LAST on 4th, done=1, err=0, slave memory 0x10..0x13 match.
REQ-032 Read addr=0x10,len=3 after REQ-031 -> rdata 0xA0..0xA3, rdata_last on 4th, RESP 01/01/01/00 accepted, err=0.
REQ-033 Read len=0 -> one beat, LAST=1; write len=255 -> 256 beats, LAST only on beat 255.
REQ-034 Slave returns RID=5 for cmd_id=2 -> done with err=1.
REQ-035 Slave never asserts AWREADY -> err=1, done after TIMEOUT cycles, AWVALID deasserted.
REQ-036 MASTER_RSTN low at beat 2 of 8-beat read -> all outputs 0 same cycle, IDLE, cmd_ready=1 first edge after release.
